// File: rtl/grf_alu_issue_if.sv
// Purpose: request, ALU, commit and debug signals of the GRF operand-issue stage.
// Latency: wires only; timing is set by the issue stage.
// Backpressure: req_ready is driven by the issue stage and depends on stall only.
interface grf_alu_issue_if #(
  parameter int WIDTH  = 32,
  parameter int NREG_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [NREG_W-1:0] req_rs;
  logic [NREG_W-1:0] req_rt;
  logic [NREG_W-1:0] req_rd;
  logic [2:0]        req_op;
  logic              stall;
  logic [WIDTH-1:0]  alu_A;
  logic [WIDTH-1:0]  alu_B;
  logic [2:0]        alu_op;
  logic [WIDTH-1:0]  alu_C;
  logic              cm_valid;
  logic [NREG_W-1:0] cm_rd;
  logic [WIDTH-1:0]  cm_data;
  logic [NREG_W-1:0] dbg_addr;
  logic [WIDTH-1:0]  dbg_data;

  // Issue-stage side.
  modport slave (
    input  req_valid, req_rs, req_rt, req_rd, req_op, stall, alu_C, dbg_addr,
    output req_ready, alu_A, alu_B, alu_op, cm_valid, cm_rd, cm_data, dbg_data
  );

  // Requester / ALU / observer side.
  modport master (
    output req_valid, req_rs, req_rt, req_rd, req_op, stall, alu_C, dbg_addr,
    input  req_ready, alu_A, alu_B, alu_op, cm_valid, cm_rd, cm_data, dbg_data
  );
endinterface

// File: rtl/grf_alu_issue.sv
// Purpose: 32-entry register file feeding an external combinational ALU, with forwarding and write-back.
// Latency: accept edge -> ALU inputs for one cycle -> GRF write and cm_* at the following edge.
// Backpressure: stall freezes EXEC and drops req_ready; no path from req_valid to req_ready.
module grf_alu_issue #(
  parameter int WIDTH  = 32,
  parameter int NREG_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  grf_alu_issue_if.slave bus
);
  localparam int NREG = 1 << NREG_W;

  logic [WIDTH-1:0]  grf [NREG];
  logic              ex_valid;
  logic [2:0]        ex_op;
  logic [NREG_W-1:0] ex_rd;
  logic [WIDTH-1:0]  ex_A;
  logic [WIDTH-1:0]  ex_B;
  logic [WIDTH-1:0]  opnd_a;
  logic [WIDTH-1:0]  opnd_b;
  logic              accept;
  logic              commit;
  logic              fwd_en;

  // Handshake and commit qualifiers; stall alone gates acceptance.
  always_comb begin
    bus.req_ready = ~bus.stall;
    accept        = bus.req_valid & ~bus.stall;
    commit        = ex_valid & ~bus.stall;
    fwd_en        = ex_valid & ~bus.stall;
  end

  // A operand: r0 reads zero, the op in EXEC forwards its ALU result, else the GRF.
  always_comb begin
    opnd_a = grf[bus.req_rs];
    if (bus.req_rs == '0) begin
      opnd_a = '0;
    end else if (fwd_en && (ex_rd == bus.req_rs)) begin
      opnd_a = bus.alu_C;
    end
  end

  // B operand: same selection as A, indexed by rt.
  always_comb begin
    opnd_b = grf[bus.req_rt];
    if (bus.req_rt == '0) begin
      opnd_b = '0;
    end else if (fwd_en && (ex_rd == bus.req_rt)) begin
      opnd_b = bus.alu_C;
    end
  end

  // Register file write-back; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        grf[i] <= '0;
      end
    end else if (commit && (ex_rd != '0)) begin
      grf[ex_rd] <= bus.alu_C;
    end
  end

  // EXEC register: loads on accept, drains to invalid when idle, holds under stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_A     <= '0;
      ex_B     <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_op    <= bus.req_op;
      ex_rd    <= bus.req_rd;
      ex_A     <= opnd_a;
      ex_B     <= opnd_b;
    end else if (!bus.stall) begin
      ex_valid <= 1'b0;
    end
  end

  // Commit report: pulses for one cycle per retired op, including writes aimed at r0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.cm_valid <= 1'b0;
      bus.cm_rd    <= '0;
      bus.cm_data  <= '0;
    end else begin
      bus.cm_valid <= commit;
      if (commit) begin
        bus.cm_rd   <= ex_rd;
        bus.cm_data <= bus.alu_C;
      end
    end
  end

  // ALU inputs come straight from the EXEC register; debug port shows committed state only.
  always_comb begin
    bus.alu_A    = ex_A;
    bus.alu_B    = ex_B;
    bus.alu_op   = ex_op;
    bus.dbg_data = (bus.dbg_addr == '0) ? '0 : grf[bus.dbg_addr];
  end
endmodule

// File: tb/tb_grf_alu_issue.sv
// Bench for grf_alu_issue: behavioural ALU on alu_C, architectural register model,
// and a queue of expected commits tagged with the edge on which each must appear.
module tb_grf_alu_issue;
  logic clk;
  logic reset;

  grf_alu_issue_if #(.WIDTH(32), .NREG_W(5)) bus ();

  grf_alu_issue #(.WIDTH(32), .NREG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          cycle;
  int          checks;
  int          passes;
  logic        force_en;
  logic [31:0] force_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a >> b[4:0];
      3'd5:    alu_f = 32'($signed(a) >>> b[4:0]);
      default: alu_f = 32'd0;
    endcase
  endfunction

  // Stand-in for the downstream combinational ALU, with an override used to seed registers.
  always_comb bus.alu_C = force_en ? force_val : alu_f(bus.alu_A, bus.alu_B, bus.alu_op);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One clock edge, then the commit port is compared against the scoreboard head.
  task automatic tick();
    logic due_now;
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    due_now = (sb.size() > 0) && (sb[0].due == cycle);
    chk("cm_valid", {31'd0, bus.cm_valid}, {31'd0, due_now});
    if (due_now) begin
      e = sb.pop_front();
      if (bus.cm_valid === 1'b1) begin
        chk("cm_rd", {27'd0, bus.cm_rd}, {27'd0, e.rd});
        chk("cm_data", bus.cm_data, e.data);
      end
    end
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [2:0] op);
    logic [31:0] res;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    bus.req_rd    = rd;
    bus.req_op    = op;
    bus.req_valid = 1'b1;
    res = alu_f(mdl[rs], mdl[rt], op);
    sb.push_back('{rd: rd, data: res, due: cycle + 2});
    if (rd != 5'd0) mdl[rd] = res;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Seed a register: issue a zero-operand op and override the ALU result during its EXEC cycle.
  task automatic preload(input logic [4:0] rd, input logic [31:0] val);
    bus.req_rs    = 5'd0;
    bus.req_rt    = 5'd0;
    bus.req_rd    = rd;
    bus.req_op    = 3'd0;
    bus.req_valid = 1'b1;
    sb.push_back('{rd: rd, data: val, due: cycle + 2});
    mdl[rd] = val;
    tick();
    bus.req_valid = 1'b0;
    force_en  = 1'b1;
    force_val = val;
    tick();
    force_en = 1'b0;
  endtask

  task automatic dbg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    bus.dbg_addr = idx;
    #1;
    chk(tag, bus.dbg_data, exp);
  endtask

  initial begin
    cycle     = 0;
    checks    = 0;
    passes    = 0;
    force_en  = 1'b0;
    force_val = 32'd0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    bus.stall     = 1'b0;
    bus.dbg_addr  = 5'd0;
    // Reset held with an active request that must be ignored.
    reset         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rs    = 5'd1;
    bus.req_rt    = 5'd2;
    bus.req_rd    = 5'd3;
    bus.req_op    = 3'd0;
    repeat (3) tick();
    chk("rst_alu_A", bus.alu_A, 32'd0);
    chk("rst_alu_B", bus.alu_B, 32'd0);
    chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
    dbg("rst_dbg_r3", 5'd3, 32'd0);
    dbg("rst_dbg_r31", 5'd31, 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b1;
    idle(2);
    chk("idle_alu_A", bus.alu_A, 32'd0);
    dbg("idle_dbg_r3", 5'd3, 32'd0);

    // Basic add: r1 = 5, r2 = r1 + r1.
    preload(5'd1, 32'h0000_0005);
    issue(5'd1, 5'd1, 5'd2, 3'd0);
    idle(1);
    dbg("add_dbg_r2", 5'd2, 32'h0000_000A);

    // Dependent pair with no bubble: r3 = r2 - r1, r4 = r3 | r3.
    issue(5'd2, 5'd1, 5'd3, 3'd1);
    issue(5'd3, 5'd3, 5'd4, 3'd3);
    chk("fwd_alu_A", bus.alu_A, 32'h0000_0005);
    chk("fwd_alu_B", bus.alu_B, 32'h0000_0005);
    idle(1);
    dbg("fwd_dbg_r4", 5'd4, 32'h0000_0005);

    // Write aimed at r0 still reports a commit; r0 is never a forwarding source.
    issue(5'd2, 5'd0, 5'd0, 3'd0);
    issue(5'd0, 5'd0, 5'd6, 3'd3);
    chk("r0_alu_A", bus.alu_A, 32'd0);
    chk("r0_alu_B", bus.alu_B, 32'd0);
    idle(1);
    dbg("r0_dbg_r0", 5'd0, 32'd0);

    // Stall for three edges with r7 = r1 | r2 in EXEC and a request waiting.
    issue(5'd1, 5'd2, 5'd7, 3'd3);
    bus.stall     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_rs    = 5'd1;
    bus.req_rt    = 5'd1;
    bus.req_rd    = 5'd12;
    bus.req_op    = 3'd0;
    foreach (sb[i]) sb[i].due += 3;
    repeat (3) begin
      tick();
      chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("stall_alu_A", bus.alu_A, 32'h0000_0005);
      chk("stall_alu_B", bus.alu_B, 32'h0000_000A);
      chk("stall_alu_op", {29'd0, bus.alu_op}, 32'd3);
    end
    bus.req_valid = 1'b0;
    bus.stall     = 1'b0;
    tick();
    chk("unstall_ready", {31'd0, bus.req_ready}, 32'd1);
    idle(1);
    dbg("stall_dbg_r7", 5'd7, 32'h0000_000F);
    dbg("stall_dbg_r12", 5'd12, 32'd0);

    // Shifts of a negative value.
    preload(5'd5, 32'h8000_0000);
    preload(5'd8, 32'h0000_0004);
    issue(5'd5, 5'd8, 5'd9, 3'd5);
    issue(5'd5, 5'd8, 5'd10, 3'd4);
    idle(1);
    dbg("sra_dbg_r9", 5'd9, 32'hF800_0000);
    dbg("srl_dbg_r10", 5'd10, 32'h0800_0000);

    // Reset pulse between edges while an op sits in EXEC: it must never commit.
    issue(5'd1, 5'd1, 5'd11, 3'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_cm_valid", {31'd0, bus.cm_valid}, 32'd0);
    chk("midrst_alu_A", bus.alu_A, 32'd0);
    #1 reset = 1'b1;
    sb.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    idle(2);
    for (int i = 0; i < 32; i++) dbg("midrst_dbg", 5'(i), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
